ball_pool_controller: RTL and testbench

BALL_POOL_CONTROLLER -- requirements
Module: ball_pool_controller

---
 rtl/ball_pkg.sv | 21 ++
 rtl/ball_slot.sv | 65 ++++++
 rtl/ball_pool_controller.sv | 147 ++++++++++++++
 tb/tb_ball_pool_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types for the ball pool: slot lifecycle states, split allocator
// states and default timing constants.
package ball_pkg;

    typedef enum logic [1:0] {
        SLOT_INACTIVE = 2'd0,
        SLOT_ACTIVE   = 2'd1,
        SLOT_POPPING  = 2'd2,
        SLOT_SPLIT    = 2'd3
    } slot_state_t;

    typedef enum logic [1:0] {
        ALLOC_IDLE       = 2'd0,
        ALLOC_EMIT_LEFT  = 2'd1,
        ALLOC_EMIT_RIGHT = 2'd2
    } alloc_state_t;

    localparam int POP_FRAMES_DEF = 15;
    localparam int CNT_W          = 8;

endpackage

// File: rtl/ball_slot.sv
// One ball slot: lifecycle state, size code and pop-animation frame counter.
// Priority: kill > revive > hit > frame tick.
module ball_slot
    import ball_pkg::*;
#(
    parameter int SIZE_W     = 2,
    parameter int POP_FRAMES = POP_FRAMES_DEF
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              kill,
    input  logic              revive,
    input  logic [SIZE_W-1:0] reviveSize,
    input  logic              hit,
    input  logic              frameTick,
    output slot_state_t       state,
    output logic [SIZE_W-1:0] size
);

    slot_state_t       stateN;
    logic [SIZE_W-1:0] sizeN;
    logic [CNT_W-1:0]  cnt, cntN;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= SLOT_INACTIVE;
            size  <= '0;
            cnt   <= '0;
        end else begin
            state <= stateN;
            size  <= sizeN;
            cnt   <= cntN;
        end
    end

    always_comb begin
        stateN = state;
        sizeN  = size;
        cntN   = cnt;
        if (kill) begin
            stateN = SLOT_INACTIVE;
            sizeN  = '0;
            cntN   = '0;
        end else if (revive) begin
            stateN = SLOT_ACTIVE;
            sizeN  = reviveSize;
            cntN   = '0;
        end else begin
            case (state)
                SLOT_ACTIVE: if (hit) begin
                    stateN = SLOT_POPPING;
                    cntN   = CNT_W'(POP_FRAMES);
                end
                SLOT_POPPING: if (frameTick) begin
                    cntN = cnt - CNT_W'(1);
                    // last frame of the animation: smallest balls vanish, others wait for the allocator
                    if (cnt == CNT_W'(1))
                        stateN = (size == '0) ? SLOT_INACTIVE : SLOT_SPLIT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ball_pool_controller.sv
// Pool of ball slots with a shared split allocator that turns each popped
// ball into two smaller children, one spawn per cycle.
module ball_pool_controller
    import ball_pkg::*;
#(
    parameter int NUM_SLOTS  = 8,
    parameter int SIZE_W     = 2,
    parameter int POP_FRAMES = POP_FRAMES_DEF
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         levelStart,
    input  logic [SIZE_W-1:0]            initSize,
    input  logic                         hitValid,
    input  logic [$clog2(NUM_SLOTS)-1:0] hitIdx,
    output logic [NUM_SLOTS-1:0]         available,
    output logic [NUM_SLOTS-1:0]         popping,
    output logic [NUM_SLOTS*SIZE_W-1:0]  ballSize,
    output logic                         spawnValid,
    output logic [$clog2(NUM_SLOTS)-1:0] spawnIdx,
    output logic                         spawnDir,
    output logic                         allClear,
    output logic                         overflow
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    slot_state_t [NUM_SLOTS-1:0]             slotState;
    logic        [NUM_SLOTS-1:0][SIZE_W-1:0] slotSize;
    logic        [NUM_SLOTS-1:0]             inactive;
    logic        [NUM_SLOTS-1:0]             revive;

    alloc_state_t      aState, aNext;
    logic [IDX_W-1:0]  servIdx, splitIdx, freeIdx, spawnIdxN;
    logic [SIZE_W-1:0] childSize;
    logic              splitAny, freeAny, spawnGo, spawnDirN, setOvf;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        ball_slot #(
            .SIZE_W     (SIZE_W),
            .POP_FRAMES (POP_FRAMES)
        ) u_slot (
            .clk        (clk),
            .resetN     (resetN),
            .kill       (levelStart && (g != 0)),
            .revive     (revive[g]),
            .reviveSize (levelStart ? initSize : childSize),
            .hit        (hitValid && (hitIdx == IDX_W'(g))),
            .frameTick  (startOfFrame),
            .state      (slotState[g]),
            .size       (slotSize[g])
        );
        assign inactive[g]  = (slotState[g] == SLOT_INACTIVE);
        assign available[g] = (slotState[g] == SLOT_ACTIVE);
        assign popping[g]   = (slotState[g] == SLOT_POPPING) || (slotState[g] == SLOT_SPLIT);
    end

    assign ballSize = slotSize;
    assign allClear = &inactive;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        splitAny = 1'b0;
        splitIdx = '0;
        freeAny  = 1'b0;
        freeIdx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slotState[i] == SLOT_SPLIT) begin
                splitAny = 1'b1;
                splitIdx = IDX_W'(i);
            end
            if (inactive[i]) begin
                freeAny = 1'b1;
                freeIdx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) aState <= ALLOC_IDLE;
        else         aState <= aNext;
    end

    always_comb begin
        aNext     = aState;
        revive    = '0;
        spawnGo   = 1'b0;
        spawnIdxN = spawnIdx;
        spawnDirN = spawnDir;
        setOvf    = 1'b0;
        case (aState)
            ALLOC_IDLE: if (splitAny) aNext = ALLOC_EMIT_LEFT;
            ALLOC_EMIT_LEFT: begin
                revive[servIdx] = 1'b1;
                spawnGo         = 1'b1;
                spawnIdxN       = servIdx;
                spawnDirN       = 1'b0;
                aNext           = ALLOC_EMIT_RIGHT;
            end
            ALLOC_EMIT_RIGHT: begin
                if (freeAny) begin
                    revive[freeIdx] = 1'b1;
                    spawnGo         = 1'b1;
                    spawnIdxN       = freeIdx;
                    spawnDirN       = 1'b1;
                end else begin
                    setOvf = 1'b1;
                end
                aNext = ALLOC_IDLE;
            end
            default: aNext = ALLOC_IDLE;
        endcase
        // a new level wipes any split in flight
        if (levelStart) begin
            aNext     = ALLOC_IDLE;
            revive    = '0;
            revive[0] = 1'b1;
            setOvf    = 1'b0;
            spawnGo   = 1'b1;
            spawnIdxN = '0;
            spawnDirN = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            servIdx    <= '0;
            childSize  <= '0;
            spawnValid <= 1'b0;
            spawnIdx   <= '0;
            spawnDir   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            spawnValid <= spawnGo;
            spawnIdx   <= spawnIdxN;
            spawnDir   <= spawnDirN;
            if (levelStart)  overflow <= 1'b0;
            else if (setOvf) overflow <= 1'b1;
            if (aState == ALLOC_IDLE && splitAny) begin
                servIdx   <= splitIdx;
                childSize <= slotSize[splitIdx] - SIZE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ball_pool_controller.sv
// Self-checking bench for ball_pool_controller: directed scenarios plus a
// randomized run against a slot/split reference model.
module tb_ball_pool_controller;

    localparam int NS = 8;
    localparam int SW = 3;
    localparam int PF = 15;
    localparam int IW = 3;
    localparam int ST_I = 0, ST_A = 1, ST_P = 2, ST_S = 3;

    logic clk = 1'b0, resetN = 1'b0;
    logic startOfFrame = 1'b0, levelStart = 1'b0, hitValid = 1'b0;
    logic [SW-1:0] initSize = '0;
    logic [IW-1:0] hitIdx = '0;
    logic [NS-1:0] available, popping;
    logic [NS*SW-1:0] ballSize;
    logic spawnValid, spawnDir, allClear, overflow;
    logic [IW-1:0] spawnIdx;

    int nChecks = 0, nFails = 0, cycNo = 0;
    int spawnLog[$];
    int spawnCyc[$];

    always #5 clk = ~clk;

    ball_pool_controller #(.NUM_SLOTS(NS), .SIZE_W(SW), .POP_FRAMES(PF)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .levelStart(levelStart),
        .initSize(initSize), .hitValid(hitValid), .hitIdx(hitIdx), .available(available),
        .popping(popping), .ballSize(ballSize), .spawnValid(spawnValid), .spawnIdx(spawnIdx),
        .spawnDir(spawnDir), .allClear(allClear), .overflow(overflow)
    );

    // Reference model: per-ball state/size/frames-left, plus the split job in progress
    // (job = 0 none, 1 left child due, 2 right child due).
    int mSt[NS], mSz[NS], mCnt[NS];
    int job, jobSlot, jobChild, mIdx;
    bit mOvf, mSv, mDir;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin mSt[i] = ST_I; mSz[i] = 0; mCnt[i] = 0; end
        job = 0; jobSlot = 0; jobChild = 0; mIdx = 0; mOvf = 0; mSv = 0; mDir = 0;
    endtask

    function automatic int lowest(input int st);
        for (int i = 0; i < NS; i++) if (mSt[i] == st) return i;
        return -1;
    endfunction

    task automatic model_clock(input bit lvl, input int isz, input bit hv, input int hi, input bit sof);
        int rev, f, nextJob;
        rev = -1;
        mSv = 0;
        nextJob = job;
        if (lvl) begin
            for (int i = 0; i < NS; i++) begin mSt[i] = ST_I; mSz[i] = 0; mCnt[i] = 0; end
            mSt[0] = ST_A; mSz[0] = isz;
            job = 0; mOvf = 0; mSv = 1; mIdx = 0; mDir = 1;
            return;
        end
        if (job == 0) begin
            f = lowest(ST_S);
            if (f >= 0) begin jobSlot = f; jobChild = mSz[f] - 1; nextJob = 1; end
        end else if (job == 1) begin
            rev = jobSlot; mSv = 1; mIdx = jobSlot; mDir = 0; nextJob = 2;
        end else begin
            f = lowest(ST_I);
            if (f >= 0) begin rev = f; mSv = 1; mIdx = f; mDir = 1; end
            else mOvf = 1;
            nextJob = 0;
        end
        job = nextJob;
        for (int i = 0; i < NS; i++) begin
            if (i == rev) begin
                mSt[i] = ST_A; mSz[i] = jobChild; mCnt[i] = 0;
            end else if (mSt[i] == ST_A && hv && hi == i) begin
                mSt[i] = ST_P; mCnt[i] = PF;
            end else if (mSt[i] == ST_P && sof) begin
                mCnt[i] = mCnt[i] - 1;
                if (mCnt[i] == 0) mSt[i] = (mSz[i] == 0) ? ST_I : ST_S;
            end
        end
    endtask

    function automatic logic [NS-1:0] exp_avail();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = (mSt[i] == ST_A);
        return v;
    endfunction

    function automatic logic [NS-1:0] exp_pop();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = (mSt[i] == ST_P) || (mSt[i] == ST_S);
        return v;
    endfunction

    function automatic logic [NS*SW-1:0] exp_sizes();
        logic [NS*SW-1:0] v;
        for (int i = 0; i < NS; i++) v[i*SW +: SW] = SW'(mSz[i]);
        return v;
    endfunction

    function automatic logic exp_clear();
        for (int i = 0; i < NS; i++) if (mSt[i] != ST_I) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive inputs, advance the model at the edge, log any spawn just after it.
    task automatic cyc(input bit lvl, input int isz, input bit hv, input int hi, input bit sof);
        levelStart = lvl; initSize = SW'(isz); hitValid = hv; hitIdx = IW'(hi); startOfFrame = sof;
        @(posedge clk);
        model_clock(lvl, isz, hv, hi, sof);
        cycNo++;
        #1;
        levelStart = 0; hitValid = 0; startOfFrame = 0;
        if (spawnValid) begin spawnLog.push_back(int'(spawnIdx) * 2 + int'(spawnDir)); spawnCyc.push_back(cycNo); end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic pop(input int idx);
        cyc(0, 0, 1, idx, 0);
        for (int i = 0; i < PF; i++) cyc(0, 0, 0, 0, 1);
        idle(4);
    endtask

    function automatic int sz_of(input logic [NS*SW-1:0] v, input int i);
        return int'(v[i*SW +: SW]);
    endfunction

    task automatic test_reset();
        #12;
        nChecks++; if (available !== 8'h00) begin nFails++; $display("FAIL rst_avail got %h want 00", available); end
        nChecks++; if (popping !== 8'h00) begin nFails++; $display("FAIL rst_pop got %h want 00", popping); end
        nChecks++; if (ballSize !== '0) begin nFails++; $display("FAIL rst_size got %h want 0", ballSize); end
        nChecks++; if ({spawnValid, spawnIdx, spawnDir} !== 5'b0) begin nFails++; $display("FAIL rst_spawn got %b%h%b want 0", spawnValid, spawnIdx, spawnDir); end
        nChecks++; if ({allClear, overflow} !== 2'b10) begin nFails++; $display("FAIL rst_clr_ovf got %b want 10", {allClear, overflow}); end
        model_reset();
        #4 resetN = 1'b1;
        #1;
    endtask

    task automatic test_level_start();
        cyc(1, 2, 0, 0, 0);
        nChecks++; if ({spawnValid, spawnIdx, spawnDir} !== {1'b1, 3'd0, 1'b1}) begin nFails++; $display("FAIL lvl_spawn got %b/%0d/%b want 1/0/1", spawnValid, spawnIdx, spawnDir); end
        nChecks++; if (available !== 8'h01) begin nFails++; $display("FAIL lvl_avail got %h want 01", available); end
        nChecks++; if (allClear !== 1'b0) begin nFails++; $display("FAIL lvl_clear got %b want 0", allClear); end
        nChecks++; if (sz_of(ballSize, 0) != 2) begin nFails++; $display("FAIL lvl_size got %0d want 2", sz_of(ballSize, 0)); end
        cyc(0, 0, 0, 0, 0);
        nChecks++; if (spawnValid !== 1'b0) begin nFails++; $display("FAIL lvl_pulse got %b want 0", spawnValid); end
    endtask

    task automatic test_split();
        cyc(0, 0, 1, 0, 0);
        nChecks++; if ({available, popping} !== 16'h0001) begin nFails++; $display("FAIL hit_state got %h want 0001", {available, popping}); end
        for (int i = 0; i < PF - 1; i++) cyc(0, 0, 0, 0, 1);
        nChecks++; if (popping !== 8'h01) begin nFails++; $display("FAIL pop_early got %h want 01", popping); end
        spawnLog.delete(); spawnCyc.delete();
        cyc(0, 0, 0, 0, 1);
        idle(4);
        nChecks++; if (spawnLog.size() != 2) begin nFails++; $display("FAIL split_count got %0d want 2", spawnLog.size()); end
        else begin
            nChecks++; if (spawnLog[0] != 0 || spawnLog[1] != 3) begin nFails++; $display("FAIL split_order got %0d,%0d want 0,3", spawnLog[0], spawnLog[1]); end
            nChecks++; if (spawnCyc[1] - spawnCyc[0] != 1) begin nFails++; $display("FAIL split_gap got %0d want 1", spawnCyc[1] - spawnCyc[0]); end
        end
        nChecks++; if ({available, popping} !== 16'h0300) begin nFails++; $display("FAIL split_state got %h want 0300", {available, popping}); end
        nChecks++; if (sz_of(ballSize, 0) != 1 || sz_of(ballSize, 1) != 1) begin nFails++; $display("FAIL split_size got %0d,%0d want 1,1", sz_of(ballSize, 0), sz_of(ballSize, 1)); end
    endtask

    task automatic test_back_to_back();
        cyc(1, 3, 0, 0, 0);
        pop(0); pop(0); pop(1);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 3, 0);
        spawnLog.delete(); spawnCyc.delete();
        for (int i = 0; i < PF; i++) cyc(0, 0, 0, 0, 1);
        idle(8);
        nChecks++; if (spawnLog.size() != 4) begin nFails++; $display("FAIL b2b_count got %0d want 4", spawnLog.size()); end
        else begin
            nChecks++; if (spawnLog[0] != 2 || spawnLog[1] != 9 || spawnLog[2] != 6 || spawnLog[3] != 11)
                begin nFails++; $display("FAIL b2b_order got %0d,%0d,%0d,%0d want 2,9,6,11", spawnLog[0], spawnLog[1], spawnLog[2], spawnLog[3]); end
            nChecks++; if (spawnCyc[1] - spawnCyc[0] != 1 || spawnCyc[3] - spawnCyc[2] != 1 || spawnCyc[2] <= spawnCyc[1])
                begin nFails++; $display("FAIL b2b_timing got %0d,%0d,%0d,%0d", spawnCyc[0], spawnCyc[1], spawnCyc[2], spawnCyc[3]); end
        end
        nChecks++; if (available !== 8'h3F) begin nFails++; $display("FAIL b2b_avail got %h want 3f", available); end
    endtask

    task automatic test_overflow();
        cyc(1, 4, 0, 0, 0);
        pop(0); pop(0); pop(1); pop(0); pop(1); pop(2); pop(3);
        nChecks++; if ({available, overflow} !== 9'h1FE) begin nFails++; $display("FAIL ovf_full got %h want 1fe", {available, overflow}); end
        spawnLog.delete(); spawnCyc.delete();
        pop(0);
        nChecks++; if (spawnLog.size() != 1 || spawnLog[0] != 0) begin nFails++; $display("FAIL ovf_spawns got n=%0d want one (0,left)", spawnLog.size()); end
        nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_set got %b want 1", overflow); end
        nChecks++; if (available !== 8'hFF || sz_of(ballSize, 0) != 0) begin nFails++; $display("FAIL ovf_slot got %h/%0d want ff/0", available, sz_of(ballSize, 0)); end
        idle(10);
        nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        cyc(1, 1, 0, 0, 0);
        nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_size_zero();
        cyc(1, 0, 0, 0, 0);
        spawnLog.delete(); spawnCyc.delete();
        pop(0);
        nChecks++; if (spawnLog.size() != 0) begin nFails++; $display("FAIL zero_spawn got %0d want 0", spawnLog.size()); end
        nChecks++; if ({available, popping, allClear} !== 17'h00001) begin nFails++; $display("FAIL zero_state got %h want 00001", {available, popping, allClear}); end
    endtask

    task automatic test_reset_mid_split();
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < PF; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        #2 resetN = 1'b0;
        #1;
        nChecks++; if ({available, popping, ballSize} !== '0) begin nFails++; $display("FAIL rmid_slots got %h want 0", {available, popping, ballSize}); end
        nChecks++; if ({spawnValid, spawnIdx, spawnDir, allClear, overflow} !== 7'b0000010) begin nFails++; $display("FAIL rmid_out got %b want 0000010", {spawnValid, spawnIdx, spawnDir, allClear, overflow}); end
        model_reset();
        #2 resetN = 1'b1;
        spawnLog.delete(); spawnCyc.delete();
        idle(10);
        nChecks++; if (spawnLog.size() != 0 || allClear !== 1'b1) begin nFails++; $display("FAIL rmid_after got n=%0d clr=%b want 0/1", spawnLog.size(), allClear); end
    endtask

    task automatic test_random();
        bit lvl, hv, sof;
        cyc(1, 7, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            lvl = ($urandom_range(0, 79) == 0);
            hv  = ($urandom_range(0, 2) == 0);
            sof = ($urandom_range(0, 1) == 0);
            cyc(lvl, int'($urandom_range(0, 7)), hv, int'($urandom_range(0, NS - 1)), sof);
            nChecks++; if (available !== exp_avail()) begin nFails++; $display("FAIL rnd_avail c%0d got %h want %h", cycNo, available, exp_avail()); end
            nChecks++; if (popping !== exp_pop()) begin nFails++; $display("FAIL rnd_pop c%0d got %h want %h", cycNo, popping, exp_pop()); end
            nChecks++; if (ballSize !== exp_sizes()) begin nFails++; $display("FAIL rnd_size c%0d got %h want %h", cycNo, ballSize, exp_sizes()); end
            nChecks++; if ({spawnValid, spawnIdx, spawnDir} !== {mSv, IW'(mIdx), mDir}) begin nFails++; $display("FAIL rnd_spawn c%0d got %b/%0d/%b want %b/%0d/%b", cycNo, spawnValid, spawnIdx, spawnDir, mSv, mIdx, mDir); end
            nChecks++; if ({allClear, overflow} !== {exp_clear(), mOvf}) begin nFails++; $display("FAIL rnd_clr_ovf c%0d got %b%b want %b%b", cycNo, allClear, overflow, exp_clear(), mOvf); end
        end
    endtask

    initial begin
        test_reset();
        test_level_start();
        test_split();
        test_back_to_back();
        test_overflow();
        test_size_zero();
        test_reset_mid_split();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
